// File: rtl/tsip_timing_decoder.sv
// TSIP deframer for the Thunderbolt GPSDO byte stream.
// Decodes the primary timing packet into registered UTC time-of-day fields.
module tsip_timing_decoder #(
    parameter logic [7:0] PKT_ID      = 8'h8F,
    parameter logic [7:0] SUBCODE     = 8'hAB,
    parameter int         PAYLOAD_LEN = 17
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    output logic        o_packet_dv,
    output logic [15:0] o_year,
    output logic [7:0]  o_month,
    output logic [7:0]  o_day,
    output logic [7:0]  o_hour,
    output logic [7:0]  o_minutes,
    output logic [7:0]  o_seconds,
    output logic [7:0]  o_timing_flag,
    output logic        o_frame_err
);

    localparam logic [7:0] DLE     = 8'h10;
    localparam logic [7:0] ETX     = 8'h03;
    localparam logic [4:0] LEN_W   = 5'(PAYLOAD_LEN);
    localparam logic [4:0] CNT_MAX = 5'd31;

    typedef enum logic [1:0] {S_IDLE, S_ID, S_DATA, S_DLE} state_t;

    state_t      state_q, state_d;
    logic        match_q, match_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [7:0]  stg_flag_q, stg_flag_d;
    logic [7:0]  stg_sec_q, stg_sec_d;
    logic [7:0]  stg_min_q, stg_min_d;
    logic [7:0]  stg_hour_q, stg_hour_d;
    logic [7:0]  stg_day_q, stg_day_d;
    logic [7:0]  stg_month_q, stg_month_d;
    logic [7:0]  stg_year_hi_q, stg_year_hi_d;
    logic [7:0]  stg_year_lo_q, stg_year_lo_d;

    logic        packet_dv_q, packet_dv_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] year_q, year_d;
    logic [7:0]  month_q, month_d;
    logic [7:0]  day_q, day_d;
    logic [7:0]  hour_q, hour_d;
    logic [7:0]  minutes_q, minutes_d;
    logic [7:0]  seconds_q, seconds_d;
    logic [7:0]  flag_q, flag_d;

    logic        data_wr;
    logic [7:0]  data_val;
    logic        new_id;
    logic        eop;
    logic        range_ok;

    assign range_ok = (stg_month_q >= 8'd1) && (stg_month_q <= 8'd12) &&
                      (stg_day_q   >= 8'd1) && (stg_day_q   <= 8'd31) &&
                      (stg_hour_q  <= 8'd23) && (stg_min_q  <= 8'd59) &&
                      (stg_sec_q   <= 8'd60);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            match_q       <= 1'b0;
            cnt_q         <= '0;
            // NOTE: staging registers are cleared too, so a reset mid-packet leaves no stale fields behind.
            stg_flag_q    <= '0;
            stg_sec_q     <= '0;
            stg_min_q     <= '0;
            stg_hour_q    <= '0;
            stg_day_q     <= '0;
            stg_month_q   <= '0;
            stg_year_hi_q <= '0;
            stg_year_lo_q <= '0;
            packet_dv_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            year_q        <= '0;
            month_q       <= '0;
            day_q         <= '0;
            hour_q        <= '0;
            minutes_q     <= '0;
            seconds_q     <= '0;
            flag_q        <= '0;
        end else begin
            state_q       <= state_d;
            match_q       <= match_d;
            cnt_q         <= cnt_d;
            stg_flag_q    <= stg_flag_d;
            stg_sec_q     <= stg_sec_d;
            stg_min_q     <= stg_min_d;
            stg_hour_q    <= stg_hour_d;
            stg_day_q     <= stg_day_d;
            stg_month_q   <= stg_month_d;
            stg_year_hi_q <= stg_year_hi_d;
            stg_year_lo_q <= stg_year_lo_d;
            packet_dv_q   <= packet_dv_d;
            frame_err_q   <= frame_err_d;
            year_q        <= year_d;
            month_q       <= month_d;
            day_q         <= day_d;
            hour_q        <= hour_d;
            minutes_q     <= minutes_d;
            seconds_q     <= seconds_d;
            flag_q        <= flag_d;
        end
    end

    // NOTE: defaulting every comb output up front prevents latch inference on untaken branches.
    always_comb begin
        state_d = state_q;
        if (i_rx_dv) begin
            unique case (state_q)
                S_IDLE: if (i_rx_byte == DLE) state_d = S_ID;
                S_ID:   state_d = (i_rx_byte == DLE || i_rx_byte == ETX) ? S_IDLE : S_DATA;
                S_DATA: if (i_rx_byte == DLE) state_d = S_DLE;
                S_DLE:  state_d = (i_rx_byte == ETX) ? S_IDLE : S_DATA;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        match_d       = match_q;
        cnt_d         = cnt_q;
        stg_flag_d    = stg_flag_q;
        stg_sec_d     = stg_sec_q;
        stg_min_d     = stg_min_q;
        stg_hour_d    = stg_hour_q;
        stg_day_d     = stg_day_q;
        stg_month_d   = stg_month_q;
        stg_year_hi_d = stg_year_hi_q;
        stg_year_lo_d = stg_year_lo_q;
        packet_dv_d   = 1'b0;
        frame_err_d   = 1'b0;
        year_d        = year_q;
        month_d       = month_q;
        day_d         = day_q;
        hour_d        = hour_q;
        minutes_d     = minutes_q;
        seconds_d     = seconds_q;
        flag_d        = flag_q;
        data_wr       = 1'b0;
        data_val      = i_rx_byte;
        new_id        = 1'b0;
        eop           = 1'b0;

        if (i_rx_dv) begin
            unique case (state_q)
                S_ID:   new_id = (i_rx_byte != DLE) && (i_rx_byte != ETX);
                S_DATA: data_wr = (i_rx_byte != DLE);
                S_DLE: begin
                    if (i_rx_byte == DLE) begin
                        data_wr = 1'b1;
                    end else if (i_rx_byte == ETX) begin
                        eop = 1'b1;
                    end else begin
                        // A stray DLE-x pair aborts the frame and x is taken as the next ID.
                        frame_err_d = match_q;
                        new_id      = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (new_id) begin
            match_d = (i_rx_byte == PKT_ID);
            cnt_d   = '0;
        end

        if (data_wr) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 5'd1;
            if (cnt_q < LEN_W) begin
                case (cnt_q)
                    5'd0:  if (data_val != SUBCODE) match_d = 1'b0;
                    5'd9:  stg_flag_d    = data_val;
                    5'd10: stg_sec_d     = data_val;
                    5'd11: stg_min_d     = data_val;
                    5'd12: stg_hour_d    = data_val;
                    5'd13: stg_day_d     = data_val;
                    5'd14: stg_month_d   = data_val;
                    5'd15: stg_year_hi_d = data_val;
                    5'd16: stg_year_lo_d = data_val;
                    default: ;
                endcase
            end
        end

        if (eop && match_q) begin
            if (cnt_q != LEN_W || !range_ok) begin
                frame_err_d = 1'b1;
            end else begin
                packet_dv_d = 1'b1;
                year_d      = {stg_year_hi_q, stg_year_lo_q};
                month_d     = stg_month_q;
                day_d       = stg_day_q;
                hour_d      = stg_hour_q;
                minutes_d   = stg_min_q;
                seconds_d   = stg_sec_q;
                flag_d      = stg_flag_q;
            end
        end
    end

    assign o_packet_dv   = packet_dv_q;
    assign o_frame_err   = frame_err_q;
    assign o_year        = year_q;
    assign o_month       = month_q;
    assign o_day         = day_q;
    assign o_hour        = hour_q;
    assign o_minutes     = minutes_q;
    assign o_seconds     = seconds_q;
    assign o_timing_flag = flag_q;

endmodule

// File: tb/tb_tsip_timing_decoder.sv
// Directed bench for tsip_timing_decoder: expected events are queued as each
// stream is driven and popped by a monitor when the decoder pulses.
module tb_tsip_timing_decoder;

    localparam logic [7:0] DLE = 8'h10;
    localparam logic [7:0] ETX = 8'h03;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_rx_dv = 1'b0;
    logic [7:0]  i_rx_byte = '0;
    logic        o_packet_dv;
    logic [15:0] o_year;
    logic [7:0]  o_month, o_day, o_hour, o_minutes, o_seconds, o_timing_flag;
    logic        o_frame_err;

    tsip_timing_decoder dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_rx_dv       (i_rx_dv),
        .i_rx_byte     (i_rx_byte),
        .o_packet_dv   (o_packet_dv),
        .o_year        (o_year),
        .o_month       (o_month),
        .o_day         (o_day),
        .o_hour        (o_hour),
        .o_minutes     (o_minutes),
        .o_seconds     (o_seconds),
        .o_timing_flag (o_timing_flag),
        .o_frame_err   (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        is_err;
        logic [15:0] year;
        logic [7:0]  mo, d, h, mi, s, flag;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    logic [7:0] stream[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_outs(input exp_t e);
        check("year",    32'(o_year),        32'(e.year));
        check("month",   32'(o_month),       32'(e.mo));
        check("day",     32'(o_day),         32'(e.d));
        check("hour",    32'(o_hour),        32'(e.h));
        check("minutes", 32'(o_minutes),     32'(e.mi));
        check("seconds", 32'(o_seconds),     32'(e.s));
        check("flag",    32'(o_timing_flag), 32'(e.flag));
    endtask

    task automatic expect_commit(input logic [15:0] y, input logic [7:0] mo, d, h, mi, s, flag);
        cur = '{is_err: 1'b0, year: y, mo: mo, d: d, h: h, mi: mi, s: s, flag: flag};
        sb.push_back(cur);
    endtask

    task automatic expect_err();
        exp_t e;
        e        = cur;
        e.is_err = 1'b1;
        sb.push_back(e);
    endtask

    // Append one framed packet; len payload bytes are taken from the 17-byte template.
    task automatic build_pkt(input logic [7:0] id, sub, tow0, flag, s, mi, h, d, mo,
                             input logic [15:0] y, input int len);
        logic [7:0] pl[17];
        pl = '{sub, tow0, 8'h01, 8'h02, 8'h03, 8'h08, 8'h9A, 8'h00, 8'h12,
               flag, s, mi, h, d, mo, y[15:8], y[7:0]};
        stream.push_back(DLE);
        stream.push_back(id);
        for (int i = 0; i < len; i++) begin
            stream.push_back(pl[i]);
            if (pl[i] == DLE) stream.push_back(DLE);
        end
        stream.push_back(DLE);
        stream.push_back(ETX);
    endtask

    // Drive the stream on consecutive cycles; returns at the edge where a final-byte result is visible.
    task automatic send_stream();
        for (int i = 0; i < stream.size(); i++) begin
            @(negedge i_clk);
            i_rx_dv   = 1'b1;
            i_rx_byte = stream[i];
        end
        @(negedge i_clk);
        i_rx_dv = 1'b0;
        stream.delete();
    endtask

    task automatic idle_and_drain(input string tag);
        repeat (4) @(negedge i_clk);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (o_packet_dv && o_frame_err) check("dv_and_err_together", 32'd1, 32'd0);
        if (o_packet_dv || o_frame_err) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {30'd0, o_packet_dv, o_frame_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("event_kind", {30'd0, o_packet_dv, o_frame_err},
                      e.is_err ? 32'd1 : 32'd2);
                check_outs(e);
            end
        end
    end

    initial begin
        cur = '0;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_dv",  32'(o_packet_dv), 32'd0);
        check("rst_err", 32'(o_frame_err), 32'd0);
        check_outs(cur);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Valid packet: 2024/3/15 12:34:56
        expect_commit(16'd2024, 8'd3, 8'd15, 8'd12, 8'd34, 8'd56, 8'h05);
        build_pkt(8'h8F, 8'hAB, 8'h00, 8'h05, 8'd56, 8'd34, 8'd12, 8'd15, 8'd3, 16'h07E8, 17);
        send_stream();
        check("latency_dv_a", 32'(o_packet_dv), 32'd1);
        @(negedge i_clk);
        check("pulse_width_a", 32'(o_packet_dv), 32'd0);
        idle_and_drain("drain_a");
        check_outs(cur);

        // Stuffed TOW byte and seconds=0x10
        expect_commit(16'd2024, 8'd3, 8'd15, 8'd12, 8'd34, 8'd16, 8'h05);
        build_pkt(8'h8F, 8'hAB, 8'h10, 8'h05, 8'h10, 8'd34, 8'd12, 8'd15, 8'd3, 16'h07E8, 17);
        send_stream();
        check("latency_dv_b", 32'(o_packet_dv), 32'd1);
        idle_and_drain("drain_b");

        // Wrong subcode, then foreign packet ID, back to back: silently dropped
        build_pkt(8'h8F, 8'hAC, 8'h00, 8'h07, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 16'd2030, 17);
        build_pkt(8'h47, 8'hAB, 8'h00, 8'h07, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 16'd2030, 17);
        send_stream();
        idle_and_drain("drain_ignored");
        check_outs(cur);

        // Short payload, then month=13: both rejected
        expect_err();
        build_pkt(8'h8F, 8'hAB, 8'h00, 8'h07, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 16'd2030, 16);
        send_stream();
        check("latency_err_short", 32'(o_frame_err), 32'd1);
        idle_and_drain("drain_short");
        expect_err();
        build_pkt(8'h8F, 8'hAB, 8'h00, 8'h07, 8'd1, 8'd2, 8'd3, 8'd4, 8'd13, 16'd2030, 17);
        send_stream();
        check("latency_err_month", 32'(o_frame_err), 32'd1);
        idle_and_drain("drain_month");
        check_outs(cur);

        // Range boundaries accepted: 2025/12/31 23:59:60
        expect_commit(16'd2025, 8'd12, 8'd31, 8'd23, 8'd59, 8'd60, 8'h0F);
        build_pkt(8'h8F, 8'hAB, 8'h00, 8'h0F, 8'd60, 8'd59, 8'd23, 8'd31, 8'd12, 16'd2025, 17);
        send_stream();
        idle_and_drain("drain_bounds");

        // Mid-payload DLE 0x55: error, remainder ignored
        expect_err();
        stream = '{DLE, 8'h8F, 8'hAB, 8'h01, 8'h02, 8'h03, 8'h08, DLE, 8'h55, DLE, ETX};
        send_stream();
        idle_and_drain("drain_dle55");

        // Mid-payload restart: aborted frame errors, resynchronised packet commits
        expect_err();
        expect_commit(16'd2024, 8'd3, 8'd15, 8'd12, 8'd34, 8'd56, 8'h05);
        stream = '{DLE, 8'h8F, 8'hAB, 8'h01, 8'h02, 8'h03, 8'h08};
        build_pkt(8'h8F, 8'hAB, 8'h00, 8'h05, 8'd56, 8'd34, 8'd12, 8'd15, 8'd3, 16'h07E8, 17);
        send_stream();
        check("latency_dv_resync", 32'(o_packet_dv), 32'd1);
        idle_and_drain("drain_resync");

        // Reset asserted for one cycle on payload byte k=8, rest of the packet still sent
        build_pkt(8'h8F, 8'hAB, 8'h00, 8'h05, 8'd56, 8'd34, 8'd12, 8'd15, 8'd3, 16'h07E8, 17);
        for (int i = 0; i < stream.size(); i++) begin
            @(negedge i_clk);
            i_rst_n   = (i != 10);
            i_rx_dv   = 1'b1;
            i_rx_byte = stream[i];
        end
        @(negedge i_clk);
        i_rx_dv = 1'b0;
        stream.delete();
        cur = '0;
        idle_and_drain("drain_reset");
        check("post_rst_dv",  32'(o_packet_dv), 32'd0);
        check("post_rst_err", 32'(o_frame_err), 32'd0);
        check_outs(cur);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
